// File: rtl/ets_phase_stepper_if.sv
// Control/status and fine-phase-shift handshake bundle for ets_phase_stepper.
// master = stepper side (drives ps_shift and status); slave = host/generator side.
interface ets_phase_stepper_if #(
    parameter int POS_W   = 10,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic               dir;
    logic [CNT_W-1:0]   step_count;
    logic [DWELL_W-1:0] dwell;
    logic               ps_done;
    logic               ps_shift;
    logic               ps_incdec;
    logic               busy;
    logic               sample_strobe;
    logic               wrap;
    logic [POS_W-1:0]   phase_pos;
    logic               done;
    logic               error;

    modport master (
        input  start, abort, dir, step_count, dwell, ps_done,
        output ps_shift, ps_incdec, busy, sample_strobe, wrap, phase_pos, done, error
    );

    modport slave (
        output start, abort, dir, step_count, dwell, ps_done,
        input  ps_shift, ps_incdec, busy, sample_strobe, wrap, phase_pos, done, error
    );
endinterface

// File: rtl/ets_phase_stepper.sv
// Equivalent-time phase-sweep sequencer: issues ps_shift/ps_done steps, dwells, strobes; all outputs registered.
// Handshake waits on ps_done indefinitely unless ETS_STEPPER_TIMEOUT_EN adds a per-phase watchdog.
module ets_phase_stepper #(
    parameter int STEPS_PER_CYCLE = 672,
    parameter int POS_W           = 10,
    parameter int CNT_W           = 16,
    parameter int DWELL_W         = 16,
    parameter int TIMEOUT         = 1024
) (
    input  logic                ps_clk,
    input  logic                reset,
    ets_phase_stepper_if.master bus
);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(STEPS_PER_CYCLE - 1);

    typedef enum logic [2:0] {IDLE, REQ, ACK, REL, DWELL} state_t;

    state_t             state, state_n;
    logic               dir_q;
    logic [CNT_W-1:0]   rem;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dcnt;
    logic               abort_pend;
    logic [POS_W-1:0]   pos;
    logic               ps_shift_q;
    logic               incdec_q;
    logic               busy_q;
    logic               strobe_q;
    logic               wrap_q;
    logic               done_q;
    logic               error_q;

    logic               accept;
    logic               step_fin;
    logic               strobe_n;
    logic               done_n;
    logic               to_hit;
    logic               expire;

    always_ff @(posedge ps_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        step_fin = 1'b0;
        strobe_n = 1'b0;
        done_n   = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                // start beats a simultaneous abort
                if (bus.start) begin
                    accept = 1'b1;
                    if (bus.step_count == '0) done_n  = 1'b1;
                    else                      state_n = REQ;
                end else if (bus.abort) begin
                    done_n = 1'b1;
                end
            end
            REQ: state_n = ACK;
            ACK: begin
                if (bus.ps_done) begin
                    state_n = REL;
                end else if (to_hit) begin
                    expire  = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            REL: begin
                if (!bus.ps_done) begin
                    step_fin = 1'b1;
                    if (abort_pend || bus.abort) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = DWELL;
                    end
                end else if (to_hit) begin
                    expire  = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            DWELL: begin
                if (bus.abort) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (dcnt == '0) begin
                    strobe_n = 1'b1;
                    if (rem == '0) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ps_clk or posedge reset) begin
        if (reset) begin
            dir_q      <= 1'b0;
            rem        <= '0;
            dwell_q    <= '0;
            dcnt       <= '0;
            abort_pend <= 1'b0;
            pos        <= '0;
            ps_shift_q <= 1'b0;
            incdec_q   <= 1'b0;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= done_n;
            strobe_q <= strobe_n;
            wrap_q   <= 1'b0;
            busy_q   <= (state != IDLE) && (state_n != IDLE);
            // Shift level follows the state one cycle late, so it falls the cycle after ps_done is seen
            ps_shift_q <= (state == REQ) || ((state == ACK) && !expire);
            if (state == REQ) incdec_q <= dir_q;

            if (accept) begin
                dir_q      <= bus.dir;
                rem        <= bus.step_count;
                dwell_q    <= bus.dwell;
                abort_pend <= 1'b0;
            end else if (state_n == IDLE) begin
                abort_pend <= 1'b0;
            end else if (bus.abort && (state == REQ || state == ACK || state == REL)) begin
                abort_pend <= 1'b1;
            end

            if (step_fin) begin
                rem  <= rem - CNT_W'(1);
                dcnt <= dwell_q;
                if (dir_q) begin
                    pos    <= (pos == POS_MAX) ? '0 : pos + POS_W'(1);
                    wrap_q <= (pos == POS_MAX);
                end else begin
                    pos    <= (pos == '0) ? POS_MAX : pos - POS_W'(1);
                    wrap_q <= (pos == '0);
                end
            end else if (state == DWELL && dcnt != '0) begin
                dcnt <= dcnt - DWELL_W'(1);
            end
        end
    end

`ifdef ETS_STEPPER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;

    // Restarts on every state change so ACK and REL each get the full budget
    always_ff @(posedge ps_clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_n != state)                  to_cnt <= '0;
            else if (state == ACK || state == REL) to_cnt <= to_cnt + TO_W'(1);
            if (accept)      error_q <= 1'b0;
            else if (expire) error_q <= 1'b1;
        end
    end

    assign to_hit = (state == ACK || state == REL) && (to_cnt == TO_W'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT != 0);
    assign to_hit             = 1'b0;
    assign error_q            = 1'b0;
`endif

    assign bus.ps_shift      = ps_shift_q;
    assign bus.ps_incdec     = incdec_q;
    assign bus.busy          = busy_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.wrap          = wrap_q;
    assign bus.phase_pos     = pos;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
endmodule

// File: doc/ets_phase_stepper.md
# ets_phase_stepper

Phase-sweep sequencer for equivalent-time sampling. It sits directly upstream of the MMCM clock/pulse generator's fine-phase-shift port, in the `ps_clk` domain. It issues a programmed number of single-step phase-shift handshakes (`ps_shift`/`ps_done`), waits a programmable dwell after each step, and strobes the acquisition logic. It also tracks the absolute phase position modulo one output-clock period.

## Interface
Parameters:
- `STEPS_PER_CYCLE`, 672: fine-PS steps per 360° of the shifted clock (56 × CLOCK_DIV).
- `POS_W`, 10: width of `phase_pos`; must hold `STEPS_PER_CYCLE-1`.
- `CNT_W`, 16: width of `step_count`.
- `DWELL_W`, 16: width of `dwell`.
- `TIMEOUT`, 1024: `ps_clk` cycles allowed per handshake phase (timeout build only).

Ports:
- `ps_clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse; begins a sweep (ignored while `busy`).
- `abort` in 1: stop the sweep at the next safe point.
- `dir` in 1: 1 = increment phase, 0 = decrement; latched at `start`.
- `step_count` in CNT_W: number of steps; latched at `start`.
- `dwell` in DWELL_W: idle cycles after each step before `sample_strobe`; latched at `start`.
- `ps_done` in 1: handshake acknowledge from the generator; level, held until `ps_shift` falls.
- `ps_shift` out 1: step request level.
- `ps_incdec` out 1: step direction; stable whenever `ps_shift`=1.
- `busy` out 1: high from the cycle after `start` until return to IDLE.
- `sample_strobe` out 1: one-cycle pulse at end of each dwell.
- `wrap` out 1: one-cycle pulse when `phase_pos` wraps.
- `phase_pos` out POS_W: current phase position, 0..STEPS_PER_CYCLE-1.
- `done` out 1: one-cycle pulse on sweep completion or abort.
- `error` out 1: sticky handshake timeout flag; cleared by `start` or `reset`.

## Operation
- FSM states: IDLE, REQ, ACK, REL, DWELL.
- IDLE: on `start`:
  - latch `dir`, `step_count`, `dwell`.
  - If `step_count`=0, pulse `done` next cycle and stay in IDLE.
  - Otherwise go to REQ.
- REQ: drive `ps_shift`=1 and `ps_incdec`=latched dir. Go to ACK.
- ACK: hold `ps_shift`=1 until `ps_done`=1 is sampled. Then drop `ps_shift` and go to REL.
- REL: wait for `ps_done`=0. Then:
  - update `phase_pos`: +1 if dir, else −1, modulo STEPS_PER_CYCLE. Increment from STEPS_PER_CYCLE-1 goes to 0; decrement from 0 goes to STEPS_PER_CYCLE-1. Either wrap pulses `wrap`.
  - decrement the remaining-steps counter.
  - load the dwell counter and go to DWELL.
- DWELL: count `dwell` cycles, then pulse `sample_strobe`.
  - If remaining = 0: pulse `done` and go to IDLE.
  - Else go to REQ.
  - `dwell`=0 gives a strobe on the first DWELL cycle.
- `abort`:
  - in DWELL or IDLE: immediate return to IDLE with `done` (no strobe).
  - in REQ/ACK/REL: recorded. The in-flight handshake completes, `phase_pos` updates, then IDLE with `done`. An MMCM step is never abandoned.
- `start` while `busy`: ignored.
- Simultaneous `start`+`abort` in IDLE: `start` wins, and the abort is discarded.
- `phase_pos` persists across sweeps. Only `reset` zeroes it. After `reset`, software must recalibrate because the MMCM phase itself is not reset.

## Timing
- Reset values: `ps_shift`, `ps_incdec`, `busy`, `sample_strobe`, `wrap`, `done`, `error` = 0; `phase_pos` = 0; FSM = IDLE.
- All outputs are registered.
- `start` sampled at edge N → `busy`=1 and `ps_shift`=1 after edge N+1.
- `ps_done`=1 sampled at edge M → `ps_shift`=0 after edge M+1.
- `phase_pos` updates and `wrap` pulses in the cycle after `ps_done`=0 is sampled.
- `ps_shift` stays low ≥2 cycles between steps, so the generator always sees a fresh rising edge.
- Step period = handshake latency + 2 + `dwell` + 1 cycles.

## Configuration
- `ETS_STEPPER_TIMEOUT_EN` defined:
  - a counter bounds ACK and REL to TIMEOUT cycles each.
  - On expiry: set `error`, drop `ps_shift`, pulse `done`, go to IDLE. `phase_pos` is unchanged.
- Undefined: no watchdog; ACK and REL wait indefinitely; `error` is tied to 0.

## Test plan
- Generator model acking after 12 cycles; `start`, `dir`=1, `step_count`=3, `dwell`=4 → 3 `ps_shift` pulses, 3 `sample_strobe`, `phase_pos` 0→3, one `done`, `ps_incdec`=1 throughout.
- `phase_pos`=671 (preloaded by stepping), `dir`=1, `step_count`=2 → `phase_pos` 0 then 1, `wrap` pulses once. From 0 with `dir`=0, 1 step → 671 with `wrap`.
- `abort` asserted mid-ACK of step 2 of 5 → handshake completes, `phase_pos`=2, `done` pulses, no further `ps_shift`.
- `step_count`=0 → `done` one cycle after `start`, `ps_shift` never asserts, `busy` stays 0.
- `TIMEOUT`=64 with the macro defined and the model never acking → `error`=1 and `done` 64 cycles into ACK, `ps_shift`=0. A subsequent `start` clears `error`.
- `reset` asserted during DWELL → all outputs return to reset values asynchronously, and `phase_pos`=0.
